// File: rtl/keypad_code_collector.sv
// Debounces keypad scanner presses and collects DIGITS key codes
// into a buffer, presenting the finished code with valid/ack.
module keypad_code_collector #(
  parameter int          DIGITS     = 4,
  parameter int          DEBOUNCE   = 3,
  parameter logic [3:0]  CANCEL_KEY = 4'hF,
  localparam int         CW = $clog2(DIGITS + 1),
  localparam int         DW = $clog2(DEBOUNCE + 1)
) (
  input  logic                  clock,
  input  logic                  _reset,
  input  logic                  done,
  input  logic [3:0]            q3_q0,
  input  logic                  ack,
  output logic [4*DIGITS-1:0]   code,
  output logic                  valid,
  output logic [CW-1:0]         count,
  output logic                  key_strobe
);

  typedef enum logic [1:0] {
    IDLE,
    DEB,
    HELD,
    OUT
  } state_t;

  state_t              state, state_n;
  logic [3:0]          key_r, key_n;
  logic [DW-1:0]       cnt, cnt_n;
  logic [4*DIGITS-1:0] buffer, buf_n;
  logic [4*DIGITS-1:0] shifted;
  logic [CW-1:0]       count_n;
  logic                valid_n;
  logic                strobe_n;

  if (DIGITS == 1) begin : g_one
    assign shifted = key_r;
  end else begin : g_many
    assign shifted = {buffer[4*DIGITS-5:0], key_r};
  end

  always_ff @(posedge clock or negedge _reset) begin
    if (!_reset) begin
      state      <= IDLE;
      key_r      <= '0;
      cnt        <= '0;
      buffer     <= '0;
      count      <= '0;
      valid      <= 1'b0;
      key_strobe <= 1'b0;
    end else begin
      state      <= state_n;
      key_r      <= key_n;
      cnt        <= cnt_n;
      buffer     <= buf_n;
      count      <= count_n;
      valid      <= valid_n;
      key_strobe <= strobe_n;
    end
  end

  always_comb begin
    state_n  = state;
    key_n    = key_r;
    cnt_n    = cnt;
    buf_n    = buffer;
    count_n  = count;
    valid_n  = valid;
    strobe_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (done) begin
          key_n   = q3_q0;
          cnt_n   = DW'(1);
          state_n = DEB;
        end
      end
      DEB: begin
        if (!done) begin
          state_n = IDLE;
        end else if (q3_q0 != key_r) begin
          key_n = q3_q0;
          cnt_n = DW'(1);
        end else if (cnt < DW'(DEBOUNCE - 1)) begin
          cnt_n = cnt + DW'(1);
        end else begin
          state_n  = HELD;
          strobe_n = 1'b1;
          if (key_r == CANCEL_KEY) begin
            buf_n   = '0;
            count_n = '0;
          end else begin
            buf_n   = shifted;
            count_n = count + CW'(1);
          end
        end
      end
      HELD: begin
        if (!done) begin
          if (count == CW'(DIGITS)) begin
            state_n = OUT;
            valid_n = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      OUT: begin
        // back to HELD so a key held across ack needs a release first
        if (ack) begin
          buf_n   = '0;
          count_n = '0;
          valid_n = 1'b0;
          state_n = HELD;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign code = buffer;

endmodule

// File: tb/tb_keypad_code_collector.sv
// Bench for keypad_code_collector: vector table of key presses plus
// hand sequences, with a strobe scoreboard checking code/count.
module tb_keypad_code_collector;

  logic        clock;
  logic        _reset;
  logic        done;
  logic [3:0]  q3_q0;
  logic        ack;
  logic [15:0] code;
  logic        valid;
  logic [2:0]  count;
  logic        key_strobe;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          cnt;
    logic [15:0] code;
  } sb_t;

  sb_t sbq[$];

  typedef struct {
    logic [3:0]  key;
    int          hold;
    int          rel;
    bit          strobe;
    int          ecnt;
    logic [15:0] ecode;
    bit          evalid;
    bit          do_ack;
  } vec_t;

  vec_t tbl[$];

  keypad_code_collector #(
    .DIGITS(4),
    .DEBOUNCE(3),
    .CANCEL_KEY(4'hF)
  ) dut (
    .clock(clock),
    ._reset(_reset),
    .done(done),
    .q3_q0(q3_q0),
    .ack(ack),
    .code(code),
    .valid(valid),
    .count(count),
    .key_strobe(key_strobe)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (_reset && key_strobe) begin
      sb_t e;
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL strobe: unexpected pulse, code %0h count %0d",
                 code, count);
      end else begin
        e = sbq.pop_front();
        if (count !== 3'(e.cnt) || code !== e.code) begin
          fails++;
          $display("FAIL strobe: got code %0h count %0d, expected %0h %0d",
                   code, count, e.code, e.cnt);
        end
      end
    end
  end

  task automatic press(input logic [3:0] key, input int hold,
                       input int rel);
    done  = 1'b1;
    q3_q0 = key;
    repeat (hold) @(negedge clock);
    done = 1'b0;
    repeat (rel) @(negedge clock);
  endtask

  task automatic key_in(input logic [3:0] key, input int ecnt,
                        input logic [15:0] ecode, input bit evalid);
    sbq.push_back('{ecnt, ecode});
    press(key, 5, 2);
    chk("key_count", 32'(count), 32'(ecnt));
    chk("key_code", 32'(code), 32'(ecode));
    chk("key_valid", 32'(valid), 32'(evalid));
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clock);
    ack = 1'b0;
    chk("ack_valid", 32'(valid), 32'd0);
    chk("ack_count", 32'(count), 32'd0);
    chk("ack_code", 32'(code), 32'd0);
  endtask

  initial begin
    _reset = 1'b0;
    done   = 1'b1;
    q3_q0  = 4'h3;
    ack    = 1'b0;

    repeat (4) begin
      @(negedge clock);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_code", 32'(code), 32'd0);
      chk("rst_strobe", 32'(key_strobe), 32'd0);
    end
    done = 1'b0;
    @(negedge clock);
    _reset = 1'b1;
    @(negedge clock);

    tbl.push_back('{4'h1, 5, 2, 1'b1, 1, 16'h0001, 1'b0, 1'b0});
    tbl.push_back('{4'h2, 5, 2, 1'b1, 2, 16'h0012, 1'b0, 1'b0});
    tbl.push_back('{4'h3, 5, 2, 1'b1, 3, 16'h0123, 1'b0, 1'b0});
    tbl.push_back('{4'h4, 5, 2, 1'b1, 4, 16'h1234, 1'b1, 1'b1});
    tbl.push_back('{4'h7, 2, 2, 1'b0, 0, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{4'h5, 50, 2, 1'b1, 1, 16'h0005, 1'b0, 1'b0});
    tbl.push_back('{4'h9, 5, 2, 1'b1, 2, 16'h0059, 1'b0, 1'b0});
    tbl.push_back('{4'h8, 5, 2, 1'b1, 3, 16'h0598, 1'b0, 1'b0});
    tbl.push_back('{4'hF, 5, 2, 1'b1, 0, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{4'h9, 5, 2, 1'b1, 1, 16'h0009, 1'b0, 1'b0});
    tbl.push_back('{4'h8, 5, 2, 1'b1, 2, 16'h0098, 1'b0, 1'b0});
    tbl.push_back('{4'hF, 5, 2, 1'b1, 0, 16'h0000, 1'b0, 1'b0});
    tbl.push_back('{4'h1, 5, 2, 1'b1, 1, 16'h0001, 1'b0, 1'b0});
    tbl.push_back('{4'h2, 5, 2, 1'b1, 2, 16'h0012, 1'b0, 1'b0});
    tbl.push_back('{4'h3, 5, 2, 1'b1, 3, 16'h0123, 1'b0, 1'b0});
    tbl.push_back('{4'h4, 5, 2, 1'b1, 4, 16'h1234, 1'b1, 1'b1});

    foreach (tbl[i]) begin
      if (tbl[i].strobe) sbq.push_back('{tbl[i].ecnt, tbl[i].ecode});
      press(tbl[i].key, tbl[i].hold, tbl[i].rel);
      chk("vec_count", 32'(count), 32'(tbl[i].ecnt));
      chk("vec_code", 32'(code), 32'(tbl[i].ecode));
      chk("vec_valid", 32'(valid), 32'(tbl[i].evalid));
      if (tbl[i].do_ack) do_ack();
      @(negedge clock);
    end

    // key changes 7 -> 8 mid-debounce: 8 needs three samples of its own
    done  = 1'b1;
    q3_q0 = 4'h7;
    @(negedge clock);
    chk("chg_strobe0", 32'(key_strobe), 32'd0);
    q3_q0 = 4'h8;
    sbq.push_back('{1, 16'h0008});
    @(negedge clock);
    chk("chg_strobe1", 32'(key_strobe), 32'd0);
    @(negedge clock);
    chk("chg_strobe2", 32'(key_strobe), 32'd0);
    @(negedge clock);
    chk("chg_strobe3", 32'(key_strobe), 32'd1);
    done = 1'b0;
    repeat (2) @(negedge clock);
    chk("chg_count", 32'(count), 32'd1);
    chk("chg_code", 32'(code), 32'h0008);

    // ack while a key is held
    key_in(4'h1, 2, 16'h0081, 1'b0);
    key_in(4'h2, 3, 16'h0812, 1'b0);
    key_in(4'h3, 4, 16'h8123, 1'b1);
    done  = 1'b1;
    q3_q0 = 4'h6;
    repeat (2) @(negedge clock);
    chk("out_valid", 32'(valid), 32'd1);
    chk("out_count", 32'(count), 32'd4);
    chk("out_code", 32'(code), 32'h8123);
    do_ack();
    repeat (10) @(negedge clock);
    chk("held_count", 32'(count), 32'd0);
    chk("held_valid", 32'(valid), 32'd0);
    done = 1'b0;
    repeat (2) @(negedge clock);
    key_in(4'h2, 1, 16'h0002, 1'b0);

    // asynchronous reset in the middle of an entry
    key_in(4'h7, 2, 16'h0027, 1'b0);
    #2 _reset = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_code", 32'(code), 32'd0);
    @(negedge clock);
    _reset = 1'b1;
    @(negedge clock);
    key_in(4'h5, 1, 16'h0005, 1'b0);

    repeat (3) @(negedge clock);
    chk("sb_empty", 32'(sbq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
